// File: rtl/hex_display_pkg.sv
// -----------------------------------------------------------------------------
// hex_display_pkg
// Purpose : Shared types and constants for the hex display bank: the display
//           mode enum, the fixed active-low segment patterns, and a width
//           helper for the digit-select port.
// Contents: mode_e, SEG_BLANK, SEG_ALL_ON, SEG_ZERO, sel_width()
// -----------------------------------------------------------------------------
package hex_display_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_BLANK  = 2'd2,
        MODE_TEST   = 2'd3
    } mode_e;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_ALL_ON = 7'b0000000;
    localparam logic [6:0] SEG_ZERO   = 7'b1000000;

    // A single-digit bank still needs a 1-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// -----------------------------------------------------------------------------
// hex_seg_decode
// Purpose : Combinational 4-bit to 7-segment decoder, active-low outputs,
//           segment order {g,f,e,d,c,b,a}. Lower-case b and d are used so that
//           B/8 and D/0 remain distinguishable.
// Ports   : i_nibble  in  [3:0]  hex value
//           o_seg     out [6:0]  active-low segment pattern
// -----------------------------------------------------------------------------
module hex_seg_decode (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'b1111111;
        case (i_nibble)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hex_display_bank.sv
// -----------------------------------------------------------------------------
// hex_display_bank
// Purpose : Bank of NUM_DIGITS hex digit registers driving 7-segment displays,
//           with per-digit load, whole-bank shift-in, a free-running blink
//           timer and four display modes. The segment outputs are registered,
//           so they lag the digit registers by one clock.
// Ports   : clk          in   system clock, rising edge
//           reset        in   asynchronous, active-high
//           load         in   write value into digit[sel]
//           shift        in   shift digits up, value enters digit 0 (wins over load)
//           sel          in   digit index for load; out-of-range is ignored
//           value        in   [3:0] nibble to store
//           mode         in   [1:0] NORMAL / BLINK / BLANK / TEST
//           blink_mask   in   [NUM_DIGITS-1:0] digits that blink in BLINK mode
//           hex          out  [7*NUM_DIGITS-1:0] active-low segments, digit i at [7i+6:7i]
//           blink_phase  out  1 = blinking digits visible
// -----------------------------------------------------------------------------
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS        = 6,
    parameter int BLINK_HALF_PERIOD = 25000000,
    localparam int SEL_W            = sel_width(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    shift,
    input  logic [SEL_W-1:0]        sel,
    input  logic [3:0]              value,
    input  logic [1:0]              mode,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    blink_phase
);

    localparam int CNT_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF_PERIOD - 1);

    logic [3:0]              r_digit [NUM_DIGITS];
    logic [CNT_W-1:0]        r_blink_cnt;
    logic                    r_blink_phase;
    logic [7*NUM_DIGITS-1:0] r_hex;

    logic [6:0]              w_seg [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] w_hex_next;
    logic                    w_sel_ok;
    mode_e                   w_mode;

    assign w_mode   = mode_e'(mode);
    assign w_sel_ok = (int'(sel) < NUM_DIGITS);

    // Digit registers: shift takes priority, an out-of-range load is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_digit[i] <= 4'h0;
            end
        end else if (shift) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                r_digit[i] <= r_digit[i-1];
            end
            r_digit[0] <= value;
        end else if (load && w_sel_ok) begin
            r_digit[sel] <= value;
        end
    end

    // Free-running blink timer; phase flips on the wrap edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == CNT_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex_seg_decode u_dec (
            .i_nibble (r_digit[g]),
            .o_seg    (w_seg[g])
        );
    end

    always_comb begin
        w_hex_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            case (w_mode)
                MODE_NORMAL: w_hex_next[7*i +: 7] = w_seg[i];
                MODE_BLINK:  w_hex_next[7*i +: 7] = (blink_mask[i] && !r_blink_phase)
                                                    ? SEG_BLANK : w_seg[i];
                MODE_BLANK:  w_hex_next[7*i +: 7] = SEG_BLANK;
                MODE_TEST:   w_hex_next[7*i +: 7] = SEG_ALL_ON;
                default:     w_hex_next[7*i +: 7] = w_seg[i];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign hex         = r_hex;
    assign blink_phase = r_blink_phase;

endmodule

// File: tb/tb_hex_display_bank.sv
// -----------------------------------------------------------------------------
// tb_hex_display_bank
// Two instances share stimulus: a 4-digit bank (2-bit sel) and a 5-digit bank
// (3-bit sel, so indices 5..7 are representable and must be ignored).
// Each driven cycle pushes the expected post-edge outputs onto a queue; they
// are popped and compared just after the edge.
// -----------------------------------------------------------------------------
module tb_hex_display_bank;

    localparam int BHP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        shift;
    logic [2:0]  sel3;
    logic [3:0]  value;
    logic [1:0]  mode;
    logic [4:0]  mask5;
    logic [27:0] hex4;
    logic [34:0] hex5;
    logic        ph4;
    logic        ph5;

    hex_display_bank #(.NUM_DIGITS(4), .BLINK_HALF_PERIOD(BHP)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .shift       (shift),
        .sel         (sel3[1:0]),
        .value       (value),
        .mode        (mode),
        .blink_mask  (mask5[3:0]),
        .hex         (hex4),
        .blink_phase (ph4)
    );

    hex_display_bank #(.NUM_DIGITS(5), .BLINK_HALF_PERIOD(BHP)) u_dut5 (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .shift       (shift),
        .sel         (sel3),
        .value       (value),
        .mode        (mode),
        .blink_mask  (mask5),
        .hex         (hex5),
        .blink_phase (ph5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0] h4;
        logic [34:0] h5;
        logic        ph;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad   = 0;

    logic [3:0] m4 [4];
    logic [3:0] m5 [5];
    int         m_cnt;
    logic       m_ph;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] disp(input logic [3:0] d, input logic [1:0] md,
                                        input logic msk, input logic ph);
        case (md)
            2'd0:    return seg_of(d);
            2'd1:    return (msk && !ph) ? 7'b1111111 : seg_of(d);
            2'd2:    return 7'b1111111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m4[i] = 4'h0;
        for (int i = 0; i < 5; i++) m5[i] = 4'h0;
        m_cnt = 0;
        m_ph  = 1'b1;
    endtask

    // Entered just after a falling edge; drives, predicts, waits one rising
    // edge, compares, and returns at the next falling edge.
    task automatic step(input logic ld, input logic sh, input logic [2:0] s,
                        input logic [3:0] v, input logic [1:0] md, input logic [4:0] mk);
        exp_t e;
        load  = ld;
        shift = sh;
        sel3  = s;
        value = v;
        mode  = md;
        mask5 = mk;
        for (int i = 0; i < 4; i++) e.h4[7*i +: 7] = disp(m4[i], md, mk[i], m_ph);
        for (int i = 0; i < 5; i++) e.h5[7*i +: 7] = disp(m5[i], md, mk[i], m_ph);
        if (sh) begin
            for (int i = 3; i > 0; i--) m4[i] = m4[i-1];
            for (int i = 4; i > 0; i--) m5[i] = m5[i-1];
            m4[0] = v;
            m5[0] = v;
        end else if (ld) begin
            m4[s[1:0]] = v;
            if (s < 3'd5) m5[s] = v;
        end
        if (m_cnt == BHP - 1) begin
            m_cnt = 0;
            m_ph  = ~m_ph;
        end else begin
            m_cnt++;
        end
        e.ph = m_ph;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk("hex4", {36'd0, hex4}, {36'd0, e.h4});
            chk("hex5", {29'd0, hex5}, {29'd0, e.h5});
            chk("phase4", {63'd0, ph4}, {63'd0, e.ph});
            chk("phase5", {63'd0, ph5}, {63'd0, e.ph});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [1:0] md, input logic [4:0] mk, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 4'h0, md, mk);
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        shift = 1'b0;
        sel3  = 3'd0;
        value = 4'h0;
        mode  = 2'd0;
        mask5 = 5'd0;
        model_reset();

        #12;
        chk("rst_hex4", {36'd0, hex4}, {36'd0, {4{7'b1000000}}});
        chk("rst_hex5", {29'd0, hex5}, {29'd0, {5{7'b1000000}}});
        chk("rst_ph4", {63'd0, ph4}, 64'd1);
        chk("rst_ph5", {63'd0, ph5}, 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // Normal display of reset digits, then a load and idle cycles.
        idle(2'd0, 5'd0, 2);
        step(1'b1, 1'b0, 3'd2, 4'hA, 2'd0, 5'd0);
        idle(2'd0, 5'd0, 2);

        // Shift in 1,2,3; then load+shift (shift wins); then out-of-range loads.
        step(1'b0, 1'b1, 3'd0, 4'h1, 2'd0, 5'd0);
        step(1'b0, 1'b1, 3'd0, 4'h2, 2'd0, 5'd0);
        step(1'b0, 1'b1, 3'd0, 4'h3, 2'd0, 5'd0);
        step(1'b1, 1'b1, 3'd3, 4'h4, 2'd0, 5'd0);
        step(1'b1, 1'b0, 3'd5, 4'hF, 2'd0, 5'd0);
        step(1'b1, 1'b0, 3'd7, 4'hE, 2'd0, 5'd0);
        step(1'b1, 1'b0, 3'd4, 4'hC, 2'd0, 5'd0);
        idle(2'd0, 5'd0, 1);

        // Blink digit 0 across several half-periods.
        idle(2'd1, 5'b00001, 12);

        // Blank, test, back to normal: digits must be intact.
        idle(2'd2, 5'd0, 3);
        idle(2'd3, 5'd0, 3);
        idle(2'd0, 5'd0, 3);

        // All hex values through every digit, random ops and modes.
        for (int v = 0; v < 16; v++) step(1'b0, 1'b1, 3'd0, v[3:0], 2'd0, 5'd0);
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7)), 4'($urandom), 2'($urandom), 5'($urandom));
        end

        // Async reset between edges while blinking, with phase currently 0.
        for (int i = 0; i < 2 * BHP && m_ph; i++) step(1'b0, 1'b0, 3'd0, 4'h0, 2'd1, 5'b11111);
        chk("pre_rst_ph", {63'd0, ph4}, 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_hex4", {36'd0, hex4}, {36'd0, {4{7'b1000000}}});
        chk("arst_hex5", {29'd0, hex5}, {29'd0, {5{7'b1000000}}});
        chk("arst_ph4", {63'd0, ph4}, 64'd1);
        chk("arst_ph5", {63'd0, ph5}, 64'd1);
        load  = 1'b1;
        shift = 1'b1;
        sel3  = 3'd1;
        value = 4'h9;
        @(posedge clk);
        #1;
        chk("rst_hold4", {36'd0, hex4}, {36'd0, {4{7'b1000000}}});
        chk("rst_hold5", {29'd0, hex5}, {29'd0, {5{7'b1000000}}});
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // First edge after reset reflects the current mode on zero digits.
        idle(2'd3, 5'd0, 1);
        idle(2'd0, 5'd0, 1);
        step(1'b1, 1'b0, 3'd1, 4'h7, 2'd0, 5'd0);
        idle(2'd1, 5'b00010, 6);

        if (sb_q.size() != 0) chk("sb_left", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
